// File: rtl/display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_pkg: shared constants and helpers for the display scanner  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package display_pkg;

  localparam logic [3:0] BCD_MAX          = 4'd9;
  localparam int         DEFAULT_N_DIGITS = 4;
  // Widest frame the helpers below are sized for.
  localparam int         MAX_DIGITS       = 16;

  function automatic logic [MAX_DIGITS-1:0] an_off(input int n);
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [3:0] digit_nibble(input logic [4*MAX_DIGITS-1:0] frame,
                                              input int k);
    return frame[4*k +: 4];
  endfunction

  function automatic logic bcd_invalid(input logic [3:0] nib);
    return nib > BCD_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_tick_gen: free-running slot prescaler with wrap tick          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module scan_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(PRESCALE)-1:0] cnt,
  output logic                        tick
);

  localparam int               c_w    = $clog2(PRESCALE);
  localparam logic [c_w-1:0]   c_last = c_w'(PRESCALE - 1);

  logic [c_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_w'(1);
    end
  end

  assign cnt  = r_cnt;
  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | display_scan_ctrl: multiplexed 7-seg scan with frame-sync updates  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module display_scan_ctrl #(
  parameter int N_DIGITS = display_pkg::DEFAULT_N_DIGITS,
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dot_in,
  input  logic                  blank_lz,
  output logic [3:0]            bin,
  output logic                  dot,
  output logic [N_DIGITS-1:0]   an,
  output logic                  upd_ack,
  output logic                  bcd_err
);

  import display_pkg::*;

  localparam int                          c_cnt_w      = $clog2(PRESCALE);
  localparam int                          c_idx_w      = $clog2(N_DIGITS);
  localparam logic [MAX_DIGITS-1:0]       c_an_off_all = an_off(N_DIGITS);
  localparam logic [N_DIGITS-1:0]         c_an_off     = c_an_off_all[N_DIGITS-1:0];
  localparam logic [c_idx_w-1:0]          c_idx_last   = c_idx_w'(N_DIGITS - 1);

  logic [c_cnt_w-1:0]      w_cnt;
  logic                    w_tick;
  logic [c_idx_w-1:0]      r_idx;
  logic [4*N_DIGITS-1:0]   r_shadow, r_active;
  logic [N_DIGITS-1:0]     r_shadow_dot, r_active_dot;
  logic                    r_pending;
  logic [N_DIGITS-1:0]     r_an;
  logic [3:0]              r_bin;
  logic                    r_dot, r_upd_ack, r_bcd_err;

  logic                    w_commit;
  logic [4*MAX_DIGITS-1:0] w_active_ext, w_shadow_ext;
  logic [N_DIGITS-1:0]     w_blank, w_an_sel;
  logic                    w_shadow_err;
  logic [3:0]              w_cur_nib;

  scan_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (w_cnt),
    .tick  (w_tick)
  );

  // Commit only at the last slot's tick so a frame is never torn.
  assign w_commit = w_tick && (r_idx == c_idx_last) && r_pending;

  always_comb begin
    w_active_ext                   = '0;
    w_shadow_ext                   = '0;
    w_active_ext[4*N_DIGITS-1:0]   = r_active;
    w_shadow_ext[4*N_DIGITS-1:0]   = r_shadow;
  end

  // Walk from the most significant digit down, tracking "all zero so far".
  always_comb begin
    logic v_zero;
    v_zero  = 1'b1;
    w_blank = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      v_zero     = v_zero && (digit_nibble(w_active_ext, k) == 4'd0);
      w_blank[k] = bcd_invalid(digit_nibble(w_active_ext, k)) ||
                   (blank_lz && (k != 0) && v_zero);
    end
  end

  always_comb begin
    w_shadow_err = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      w_shadow_err = w_shadow_err || bcd_invalid(digit_nibble(w_shadow_ext, k));
    end
  end

  always_comb begin
    w_an_sel = c_an_off;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == c_idx_w'(k)) w_an_sel[k] = 1'b0;
    end
  end

  assign w_cur_nib = digit_nibble(w_active_ext, int'(r_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_shadow     <= '0;
      r_shadow_dot <= '0;
      r_active     <= '0;
      r_active_dot <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (w_tick) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
      end
      if (w_commit) begin
        r_active     <= r_shadow;
        r_active_dot <= r_shadow_dot;
      end
      // A load in the commit cycle lands in shadow and stays pending.
      if (load) begin
        r_shadow     <= digits_in;
        r_shadow_dot <= dot_in;
        r_pending    <= 1'b1;
      end else if (w_commit) begin
        r_pending    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an      <= c_an_off;
      r_bin     <= 4'd0;
      r_dot     <= 1'b0;
      r_upd_ack <= 1'b0;
      r_bcd_err <= 1'b0;
    end else begin
      r_an      <= ((w_cnt < c_cnt_w'(DEAD)) || w_blank[r_idx]) ? c_an_off : w_an_sel;
      r_bin     <= w_cur_nib;
      r_dot     <= r_active_dot[r_idx];
      r_upd_ack <= w_commit;
      if (w_commit) r_bcd_err <= w_shadow_err;
    end
  end

  assign an      = r_an;
  assign bin     = r_bin;
  assign dot     = r_dot;
  assign upd_ack = r_upd_ack;
  assign bcd_err = r_bcd_err;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for display_scan_ctrl (N_DIGITS=4, PRESCALE=4, DEAD=1).
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int P = 4;
  localparam int D = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]  dot_in = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    bin;
  logic          dot;
  logic [N-1:0]  an;
  logic          upd_ack;
  logic          bcd_err;

  display_scan_ctrl #(
    .N_DIGITS (N),
    .PRESCALE (P),
    .DEAD     (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digits_in (digits_in),
    .dot_in    (dot_in),
    .blank_lz  (blank_lz),
    .bin       (bin),
    .dot       (dot),
    .an        (an),
    .upd_ack   (upd_ack),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; at a negedge it equals the DUT's elapsed cycles.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [3:0] bin;
    logic       dot;
    logic       err;
  } exp_t;

  exp_t slot_q[$];
  int   ack_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic exp_out(input int t, input logic [3:0] a, input logic [3:0] b,
                         input logic dp, input logic e);
    exp_t x;
    x.t = t; x.an = a; x.bin = b; x.dot = dp; x.err = e;
    slot_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, expv);
    end
  endtask

  // Monitor: compares display outputs at tagged cycles and every upd_ack pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (slot_q.size() > 0 && slot_q[0].t < cyc) begin
        e = slot_q.pop_front();
        total++; bad++;
        $display("FAIL out@%0d: never sampled (cycle now %0d)", e.t, cyc);
      end
      if (slot_q.size() > 0 && slot_q[0].t == cyc) begin
        e = slot_q.pop_front();
        total++;
        if ({an, bin, dot, bcd_err} !== {e.an, e.bin, e.dot, e.err}) begin
          bad++;
          $display("FAIL out@%0d: got an=%b bin=%h dot=%b err=%b want an=%b bin=%h dot=%b err=%b",
                   cyc, an, bin, dot, bcd_err, e.an, e.bin, e.dot, e.err);
        end
      end
      while (ack_q.size() > 0 && ack_q[0] < cyc) begin
        total++; bad++;
        $display("FAIL upd_ack@%0d: got no pulse want pulse", ack_q.pop_front());
      end
      if (upd_ack) begin
        total++;
        if (ack_q.size() > 0 && ack_q[0] == cyc) begin
          void'(ack_q.pop_front());
        end else begin
          bad++;
          $display("FAIL upd_ack@%0d: got pulse want none", cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      total++; bad++;
      $display("FAIL wait: got cycle %0d want %0d", cyc, target);
    end
  endtask

  task automatic do_load(input int t, input logic [15:0] d, input logic [3:0] dp);
    wait_cyc(t);
    digits_in = d;
    dot_in    = dp;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst an",      an,             4'b1111);
    chk("rst bin",     bin,            4'h0);
    chk("rst dot",     {3'b0, dot},    4'h0);
    chk("rst upd_ack", {3'b0, upd_ack}, 4'h0);
    chk("rst bcd_err", {3'b0, bcd_err}, 4'h0);

    // Frame 0: all-zero frame, no blanking.
    exp_out(1,  4'b1111, 4'h0, 1'b0, 1'b0);
    exp_out(3,  4'b1110, 4'h0, 1'b0, 1'b0);
    exp_out(7,  4'b1101, 4'h0, 1'b0, 1'b0);
    exp_out(11, 4'b1011, 4'h0, 1'b0, 1'b0);
    exp_out(15, 4'b0111, 4'h0, 1'b0, 1'b0);
    // Frame 1: leading-zero blanking on.
    exp_out(19, 4'b1110, 4'h0, 1'b0, 1'b0);
    exp_out(23, 4'b1111, 4'h0, 1'b0, 1'b0);
    exp_out(27, 4'b1111, 4'h0, 1'b0, 1'b0);
    exp_out(31, 4'b1111, 4'h0, 1'b0, 1'b0);
    // Frame 2: 0253 with dot on digit 1, digit 3 blanked.
    exp_out(33, 4'b1111, 4'h3, 1'b0, 1'b0);
    exp_out(35, 4'b1110, 4'h3, 1'b0, 1'b0);
    exp_out(39, 4'b1101, 4'h5, 1'b1, 1'b0);
    exp_out(43, 4'b1011, 4'h2, 1'b0, 1'b0);
    exp_out(47, 4'b1111, 4'h0, 1'b0, 1'b0);
    // Frame 3: last of two loads wins.
    exp_out(51, 4'b1110, 4'h2, 1'b0, 1'b0);
    exp_out(55, 4'b1101, 4'h2, 1'b0, 1'b0);
    exp_out(59, 4'b1011, 4'h2, 1'b0, 1'b0);
    exp_out(63, 4'b0111, 4'h2, 1'b0, 1'b0);
    // Frame 4: 1111; frame 5: 7777 loaded in the commit cycle.
    exp_out(67, 4'b1110, 4'h1, 1'b0, 1'b0);
    exp_out(79, 4'b0111, 4'h1, 1'b0, 1'b0);
    exp_out(83, 4'b1110, 4'h7, 1'b0, 1'b0);
    exp_out(87, 4'b1101, 4'h7, 1'b0, 1'b0);
    exp_out(95, 4'b0111, 4'h7, 1'b0, 1'b0);
    // Frame 6: 00A1, invalid digit 1 blanked, upper zeros blanked.
    exp_out(99,  4'b1110, 4'h1, 1'b0, 1'b1);
    exp_out(103, 4'b1111, 4'hA, 1'b0, 1'b1);
    exp_out(107, 4'b1111, 4'h0, 1'b0, 1'b1);
    exp_out(111, 4'b1111, 4'h0, 1'b0, 1'b1);
    // Frame 7: 0001 clears the error.
    exp_out(113, 4'b1111, 4'h1, 1'b0, 1'b0);
    ack_q = '{32, 48, 64, 80, 96, 112};

    rst_n = 1'b1;
    wait_cyc(16);
    blank_lz = 1'b1;
    do_load(20,  16'h0253, 4'b0010);
    do_load(36,  16'h1111, 4'b0000);
    do_load(40,  16'h2222, 4'b0000);
    do_load(52,  16'h1111, 4'b0000);
    do_load(63,  16'h7777, 4'b0000);
    do_load(84,  16'h00A1, 4'b0000);
    do_load(100, 16'h0001, 4'b0000);
    do_load(112, 16'h0999, 4'b0000);

    // Mid-slot reset with an update pending.
    wait_cyc(114);
    rst_n = 1'b0;
    #1;
    chk("midrst an",      an,              4'b1111);
    chk("midrst bin",     bin,             4'h0);
    chk("midrst upd_ack", {3'b0, upd_ack}, 4'h0);
    chk("midrst bcd_err", {3'b0, bcd_err}, 4'h0);
    repeat (2) @(negedge clk);
    while (slot_q.size() > 0) begin
      total++; bad++;
      $display("FAIL out@%0d: never sampled before reset", slot_q.pop_front().t);
    end
    while (ack_q.size() > 0) begin
      total++; bad++;
      $display("FAIL upd_ack@%0d: got no pulse want pulse", ack_q.pop_front());
    end

    // After release the pending 0999 must be gone: zeros, no ack.
    exp_out(3,  4'b1110, 4'h0, 1'b0, 1'b0);
    exp_out(7,  4'b1111, 4'h0, 1'b0, 1'b0);
    exp_out(15, 4'b1111, 4'h0, 1'b0, 1'b0);
    exp_out(19, 4'b1110, 4'h0, 1'b0, 1'b0);
    exp_out(35, 4'b1110, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    wait_cyc(40);

    while (slot_q.size() > 0) begin
      total++; bad++;
      $display("FAIL out@%0d: never sampled at end", slot_q.pop_front().t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing controller for the temperature monitor's multi-digit 7-segment display. It holds a frame of BCD digits and decimal-point flags. It drives one shared BCD-to-7-segment decoder (nibble plus dot) while cycling active-low digit enables at a fixed scan rate. It also provides inter-digit dead time, leading-zero blanking, frame-synchronous updates with an acknowledge pulse, and invalid-BCD suppression. It sits between the temperature formatting logic and the decoder/pin drivers.

## Interface
- N_DIGITS, 4, number of multiplexed digits (≥2).
- PRESCALE, 50000, clk cycles per digit slot (≥4).
- DEAD, 2, blanked cycles at start of each slot (1 ≤ DEAD < PRESCALE).
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  capture digits_in/dot_in into the shadow register this cycle.
- digits_in  in  4*N_DIGITS  BCD digits; nibble i = digit i; digit 0 is least significant.
- dot_in  in  N_DIGITS  decimal-point flag per digit.
- blank_lz  in  1  enable leading-zero blanking.
- bin  out  4  BCD nibble to the decoder.
- dot  out  1  decimal point to the decoder.
- an  out  N_DIGITS  digit enables, active-low; one-hot-low or all-ones.
- upd_ack  out  1  one-cycle pulse when the shadow is committed to the active frame.
- bcd_err  out  1  high while any active digit is >9.

## Operation
- Prescaler cnt counts 0..PRESCALE-1 and wraps. tick = (cnt == PRESCALE-1).
- Digit index idx advances on tick and wraps N_DIGITS-1 → 0. Scan order: 0,1,…,N_DIGITS-1.
- Shadow/pending:
  - load=1 writes shadow and sets pending.
  - Commit happens on tick with idx == N_DIGITS-1 (frame end) and pending=1. On commit: active ← shadow, upd_ack pulses, pending clears.
- Load in the commit cycle:
  - active takes the old shadow.
  - shadow takes the new inputs.
  - pending stays 1, so the new value commits at the next frame end.
- Repeated loads before a commit: the last load wins. Frames are never torn.
- Digit k is blanked (an all-ones for its whole slot) when either:
  - its nibble is >9, or
  - blank_lz=1, k ≠ 0, and digits k..N_DIGITS-1 are all zero.
- Digit 0 is never leading-zero blanked.
- Dead time: an = all-ones while cnt < DEAD. bin and dot are already valid during dead time.
- bin and dot show the current-slot nibble and flag even for blanked digits.
- bcd_err is recomputed from the active frame and updates the cycle after a commit.
- Mid-operation reset: all state returns to reset values immediately. The pending update is discarded.

## Timing
- Reset values:
  - Outputs: bin=0, dot=0, an=all-ones, upd_ack=0, bcd_err=0.
  - Internal: cnt=0, idx=0, active=0, shadow=0, pending=0.
- All outputs are registered. an, bin and dot reflect (idx, cnt) with 1-cycle latency.
- Slot k: an[k] is low from cycle DEAD+1 through PRESCALE of that slot, i.e. PRESCALE-DEAD cycles per slot.
- Load-to-display latency: at most N_DIGITS*PRESCALE+1 cycles. upd_ack is asserted in the cycle after the commit tick, coincident with active changing.
- Frame period: N_DIGITS*PRESCALE cycles exactly. No cycles are lost at frame wrap.

## Structure
- Shared package display_pkg holds:
  - BCD_MAX = 4'd9;
  - AN_OFF all-ones function/constant;
  - default N_DIGITS;
  - a digit-nibble extraction function.
- One sub-module: scan_tick_gen (parameter PRESCALE). Outputs cnt and tick; async active-low reset.
- All remaining logic stays in display_scan_ctrl: idx counter, shadow/active/pending registers, blank mask, output registers.

## Test plan
All scenarios use PRESCALE=4, DEAD=1, N_DIGITS=4.
- Reset release, no load:
  - an = 1111 until the first slot's cycle 2, then an = 1110 for 3 cycles, bin=0.
  - Digits 1–3 show an = 1111 only when blank_lz=1. With blank_lz=0 they show 1101, 1011, 0111.
- load digits_in=16'h0253, dot_in=4'b0010, blank_lz=1:
  - upd_ack at first frame end.
  - Next frame: bin 3,5,2 with dot=1 on digit 1. Digit 3 is blanked (an stays 1111 in slot 3).
- load 16'h1111 then 16'h2222 within the same frame → only 16'h2222 is displayed; exactly one upd_ack.
- load 16'h7777 asserted in the commit cycle while 16'h1111 is pending:
  - 1111 is displayed next frame with upd_ack.
  - 7777 follows one frame later with a second upd_ack.
- load 16'h00A1 → bcd_err=1 after commit and digit 1 is blanked; load 16'h0001 → bcd_err=0 after the next commit.
- Assert rst_n=0 mid-slot with a pending load:
  - Immediately: an=1111, upd_ack=0.
  - After release: zeros are displayed, and no upd_ack occurs without a new load.
